// File: rtl/picomips_ctrl_pkg.sv
// Shared types and default parameters for the picoMIPS run/step controller.
package picomips_ctrl_pkg;

  // Controller state encodings, visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HELD = 2'd3
  } run_state_t;

  // 50 Hz run rate and 10 ms debounce window at 50 MHz.
  localparam int unsigned DEFAULT_DIV = 1_000_000;
  localparam int unsigned DB_CYCLES   = 500_000;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser plus stability-window debouncer for one raw input.
//   fastclk, nreset : clock and async active-low reset
//   in              : raw asynchronous input
//   level           : debounced level (resets to RESET_LEVEL)
//   fall            : one-cycle pulse on each debounced high-to-low transition
module debouncer #(
  parameter int unsigned DB_CYCLES   = picomips_ctrl_pkg::DB_CYCLES,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic fastclk,
  input  logic nreset,
  input  logic in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Level follows the synchronised input only after DB_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the window.
  always_ff @(posedge fastclk or negedge nreset) begin
    if (!nreset) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      level <= RESET_LEVEL;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/picomips_run_ctrl.sv
// Run/step clock-enable controller for the picoMIPS processor.
//   fastclk, nreset : 50 MHz clock and async active-low reset
//   run_sw          : raw RUN switch (1 = run)
//   step_btn        : raw active-low step key
//   div_load/div_val: load a new run period (0 treated as 1)
//   halt_req        : halt level from the processor
//   cpu_en          : one-cycle clock-enable pulse to the processor
//   state           : controller state encoding
//   cycle_count     : number of cpu_en pulses issued (wraps)
module picomips_run_ctrl #(
  parameter int unsigned DIV_WIDTH   = 20,
  parameter int unsigned DEFAULT_DIV = picomips_ctrl_pkg::DEFAULT_DIV,
  parameter int unsigned DB_CYCLES   = picomips_ctrl_pkg::DB_CYCLES,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 fastclk,
  input  logic                 nreset,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 halt_req,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  import picomips_ctrl_pkg::*;

  logic run_db;
  logic press;
  logic run_fall_unused;
  logic step_level_unused;

  run_state_t           st_q, st_n;
  logic [DIV_WIDTH-1:0] period_q, period_n;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_n;
  logic                 cpu_en_n;
  logic [CNT_WIDTH-1:0] count_n;

  debouncer #(.DB_CYCLES(DB_CYCLES), .RESET_LEVEL(1'b0)) u_run_db (
    .fastclk (fastclk),
    .nreset  (nreset),
    .in      (run_sw),
    .level   (run_db),
    .fall    (run_fall_unused)
  );

  // Key is active-low: released is the high level, a press is a falling edge.
  debouncer #(.DB_CYCLES(DB_CYCLES), .RESET_LEVEL(1'b1)) u_step_db (
    .fastclk (fastclk),
    .nreset  (nreset),
    .in      (step_btn),
    .level   (step_level_unused),
    .fall    (press)
  );

  // Next-state, divider, period and enable computation.
  always_comb begin
    st_n      = st_q;
    period_n  = period_q;
    div_cnt_n = '0;
    cpu_en_n  = 1'b0;
    count_n   = cycle_count + CNT_WIDTH'(cpu_en);

    if (div_load) begin
      period_n = (div_val == '0) ? DIV_WIDTH'(1) : div_val;
    end

    unique case (st_q)
      ST_IDLE: begin
        if (run_db) begin
          st_n = ST_RUN;
        end else if (press) begin
          st_n = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run_db) begin
          st_n = ST_IDLE;
        end else if (halt_req) begin
          st_n = ST_HELD;
        end else if (div_load) begin
          // Reprogramming restarts the period from zero; no pulse this cycle.
          div_cnt_n = '0;
        end else if (div_cnt_q == period_q - DIV_WIDTH'(1)) begin
          cpu_en_n  = 1'b1;
          div_cnt_n = '0;
        end else begin
          div_cnt_n = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      ST_STEP: begin
        cpu_en_n = 1'b1;
        st_n     = ST_IDLE;
      end
      ST_HELD: begin
        if (!run_db) begin
          st_n = ST_IDLE;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // All controller state and outputs.
  always_ff @(posedge fastclk or negedge nreset) begin
    if (!nreset) begin
      st_q        <= ST_IDLE;
      period_q    <= DIV_WIDTH'(DEFAULT_DIV);
      div_cnt_q   <= '0;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
    end else begin
      st_q        <= st_n;
      period_q    <= period_n;
      div_cnt_q   <= div_cnt_n;
      cpu_en      <= cpu_en_n;
      cycle_count <= count_n;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_picomips_run_ctrl.sv
// Directed self-checking bench for picomips_run_ctrl (DB_CYCLES=4, DEFAULT_DIV=8).
module tb_picomips_run_ctrl;

  localparam int unsigned DW = 20;
  localparam int unsigned CW = 16;

  logic          fastclk = 1'b0;
  logic          nreset;
  logic          run_sw;
  logic          step_btn;
  logic          div_load;
  logic [DW-1:0] div_val;
  logic          halt_req;
  logic          cpu_en;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 fastclk = ~fastclk;

  picomips_run_ctrl #(
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (8),
    .DB_CYCLES   (4),
    .CNT_WIDTH   (CW)
  ) dut (
    .fastclk     (fastclk),
    .nreset      (nreset),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .div_load    (div_load),
    .div_val     (div_val),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .state       (state),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic [DW-1:0] val;
    int            first;
    int            gap;
  } reprog_vec_t;

  reprog_vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cyc(input int n = 1);
    repeat (n) @(negedge fastclk);
  endtask

  task automatic do_reset();
    @(negedge fastclk);
    nreset   = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b1;
    div_load = 1'b0;
    div_val  = '0;
    halt_req = 1'b0;
    next_cyc(3);
    nreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int c0;
    vecs[0] = '{val: 20'd3, first: 4, gap: 3};
    vecs[1] = '{val: 20'd5, first: 6, gap: 5};
    vecs[2] = '{val: 20'd8, first: 9, gap: 8};
    vecs[3] = '{val: 20'd1, first: 2, gap: 1};
    vecs[4] = '{val: 20'd0, first: 2, gap: 1};

    nreset   = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b1;
    div_load = 1'b0;
    div_val  = '0;
    halt_req = 1'b0;

    // Reset values, then stay idle with idle inputs.
    next_cyc(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_count", 32'(cycle_count), 0);
    nreset = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      next_cyc();
      if (state != 2'd0 || cpu_en) bad++;
    end
    chk("idle_hold_bad_cycles", 32'(bad), 0);
    chk("idle_state", 32'(state), 0);

    // RUN at default period 8: entry after 7 cycles, pulse every 8.
    run_sw = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      next_cyc();
      if (k == 6) chk("run_pre_entry", 32'(state), 0);
      if (k == 7) chk("run_entry", 32'(state), 1);
      if (k >= 7) chk("run_pulse", 32'(cpu_en), 32'((k >= 15) && ((k - 15) % 8 == 0)));
    end
    chk("run_count5", 32'(cycle_count), 5);
    run_sw = 1'b0;
    for (int k = 49; k <= 70; k++) begin
      next_cyc();
      chk("run_exit_no_pulse", 32'(cpu_en), 0);
      if (k == 54) chk("run_exit_late", 32'(state), 1);
      if (k == 55) chk("run_exit_idle", 32'(state), 0);
    end
    chk("run_exit_count", 32'(cycle_count), 5);

    // Reprogram the period while running.
    run_sw = 1'b1;
    next_cyc(9);
    chk("reprog_in_run", 32'(state), 1);
    foreach (vecs[i]) begin
      int kmax;
      kmax     = vecs[i].first + 2 * vecs[i].gap;
      div_load = 1'b1;
      div_val  = vecs[i].val;
      next_cyc();
      div_load = 1'b0;
      c0 = int'(cycle_count);
      for (int k = 1; k <= kmax; k++) begin
        if (k > 1) next_cyc();
        chk($sformatf("reprog_v%0d_k%0d", vecs[i].val, k), 32'(cpu_en),
            32'((k >= vecs[i].first) && ((k - vecs[i].first) % vecs[i].gap == 0)));
      end
      chk($sformatf("reprog_v%0d_count", vecs[i].val), 32'(cycle_count), 32'(c0 + 2));
    end

    // Async reset while cpu_en is continuously high; period reverts to 8.
    chk("async_pre_en", 32'(cpu_en), 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("async_cpu_en", 32'(cpu_en), 0);
    chk("async_state", 32'(state), 0);
    chk("async_count", 32'(cycle_count), 0);
    @(negedge fastclk);
    nreset = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      next_cyc();
      if (k == 7) chk("post_rst_run", 32'(state), 1);
      chk("post_rst_pulse", 32'(cpu_en), 32'(k == 15 || k == 23));
    end
    chk("post_rst_count", 32'(cycle_count), 2);

    // Step: bouncing press, long hold, release, second press.
    do_reset();
    for (int k = 0; k <= 55; k++) begin
      chk("step_pulse", 32'(cpu_en), 32'(k == 10 || k == 40));
      if (k == 9 || k == 39) chk("step_state", 32'(state), 2);
      if (k == 11 || k == 41) chk("step_back_idle", 32'(state), 0);
      if (k == 11) chk("step_count1", 32'(cycle_count), 1);
      step_btn = (k == 1) || (k >= 22 && k <= 31) || (k >= 52);
      next_cyc();
    end
    chk("step_count2", 32'(cycle_count), 2);

    // Halt at terminal count, presses ignored in HELD, exit on run_sw low.
    do_reset();
    run_sw = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      chk("halt_no_pulse", 32'(cpu_en), 0);
      if (k == 7)  chk("halt_run", 32'(state), 1);
      if (k == 15) chk("halt_held", 32'(state), 3);
      if (k == 30) chk("halt_held_after_press", 32'(state), 3);
      if (k == 46) chk("halt_held_late", 32'(state), 3);
      if (k == 47) chk("halt_idle", 32'(state), 0);
      if (k == 14) halt_req = 1'b1;
      step_btn = !(k >= 20 && k <= 29);
      if (k == 40) run_sw = 1'b0;
      next_cyc();
    end
    chk("halt_count", 32'(cycle_count), 0);
    halt_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
